// File: rtl/task_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | task_arb_pkg: shared state encoding and width helper for the answer arbiter |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package task_arb_pkg;

   typedef enum logic [1:0] {
      s_IDLE    = 2'd0,
      s_GRANT   = 2'd1,
      s_STREAM  = 2'd2,
      s_RELEASE = 2'd3
   } task_arb_state_e;

   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

`default_nettype wire

// File: rtl/task_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | task_rr_pick: round-robin priority encoder, first set req scanning from ptr |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module task_rr_pick
   import task_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic               any,
   output logic [IW-1:0]      idx
);

   logic [NUM_REQ-1:0] rot;
   logic [IW-1:0]      off;
   logic [IW:0]        sum;

   // Rotate so ptr lands at bit 0, find the lowest set bit, then rotate the index back.
   always_comb begin
      rot = NUM_REQ'({req, req} >> ptr);
      any = |req;
      off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IW'(i);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      idx = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
   end

endmodule

`default_nettype wire

// File: rtl/task_answer_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | task_answer_arbiter: round-robin sharing of the task-manager answer channel |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module task_answer_arbiter
   import task_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int SIZE_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [NUM_REQ-1:0]             i_req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
   input  logic [NUM_REQ-1:0]             i_req_last,
   input  logic [NUM_REQ*SIZE_WIDTH-1:0]  i_req_size,
   output logic [NUM_REQ-1:0]             o_req_mgr_ready,
   input  logic                           i_tmanager_ready,
   output logic                           o_tanswer_ready,
   output logic [DATA_WIDTH-1:0]          o_tdata,
   output logic                           o_tanswer_data_last,
   output logic [SIZE_WIDTH-1:0]          o_packet_size_in_bytes,
   output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
   output logic                           o_busy,
   output logic                           o_timeout
);

   localparam int IW = clog2_min1(NUM_REQ);
   localparam int CW = clog2_min1(TIMEOUT_CYCLES + 1);

   task_arb_state_e       state;
   task_arb_state_e       state_nxt;
   logic [IW-1:0]         grant;
   logic [IW-1:0]         rr_ptr;
   logic [IW-1:0]         pick_idx;
   logic                  pick_any;
   logic [SIZE_WIDTH-1:0] size_q;
   logic [CW-1:0]         cnt;
   logic                  timeout_q;

   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
   logic [SIZE_WIDTH-1:0] size_arr [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign data_arr[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      assign size_arr[k] = i_req_size[k*SIZE_WIDTH +: SIZE_WIDTH];
   end

   logic sel_ready;
   logic sel_last;
   logic wd_fire;

   assign sel_ready = i_req_ready[grant];
   assign sel_last  = i_req_last[grant];
   // Last wins over the watchdog; a dropped ready is an abort, not a timeout.
   assign wd_fire   = (state == s_STREAM) && sel_ready && !sel_last &&
                      (cnt == CW'(TIMEOUT_CYCLES - 1));

   task_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req (i_req_ready),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= s_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         s_IDLE:    if (pick_any) state_nxt = s_GRANT;
         s_GRANT:   state_nxt = s_STREAM;
         s_STREAM:  if (sel_last || !sel_ready || wd_fire) state_nxt = s_RELEASE;
         s_RELEASE: state_nxt = s_IDLE;
         default:   state_nxt = s_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         grant     <= '0;
         rr_ptr    <= '0;
         size_q    <= '0;
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= wd_fire;
         case (state)
            s_IDLE:    if (pick_any) grant <= pick_idx;
            s_GRANT: begin
               size_q <= size_arr[grant];
               cnt    <= '0;
            end
            s_STREAM:  if (cnt != {CW{1'b1}}) cnt <= cnt + CW'(1);
            s_RELEASE: rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      o_req_mgr_ready        = '0;
      o_tanswer_ready        = 1'b0;
      o_tdata                = '0;
      o_tanswer_data_last    = 1'b0;
      o_packet_size_in_bytes = '0;
      o_busy                 = (state == s_GRANT) || (state == s_STREAM);
      o_grant_id             = grant;
      o_timeout              = timeout_q;
      if (state == s_STREAM) begin
         o_tanswer_ready        = sel_ready;
         o_tdata                = data_arr[grant];
         o_tanswer_data_last    = sel_last;
         o_packet_size_in_bytes = size_q;
         o_req_mgr_ready[grant] = i_tmanager_ready;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_task_answer_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_task_answer_arbiter: scenario bench with a packet-schedule reference     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_task_answer_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int SW = 12;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N*SW-1:0] req_size;
   logic [N-1:0]    mgr_ready;
   logic            tmgr_ready;
   logic            tanswer_ready;
   logic [DW-1:0]   tdata;
   logic            tlast;
   logic [SW-1:0]   psize;
   logic [1:0]      grant_id;
   logic            busy;
   logic            timeout;

   int total = 0;
   int bad   = 0;
   int m_ptr = 0;
   int m_gid = 0;

   always #5 clk = ~clk;

   task_answer_arbiter #(
      .NUM_REQ        (N),
      .DATA_WIDTH     (DW),
      .SIZE_WIDTH     (SW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk                  (clk),
      .i_rst                  (rst),
      .i_req_ready            (req_ready),
      .i_req_data             (req_data),
      .i_req_last             (req_last),
      .i_req_size             (req_size),
      .o_req_mgr_ready        (mgr_ready),
      .i_tmanager_ready       (tmgr_ready),
      .o_tanswer_ready        (tanswer_ready),
      .o_tdata                (tdata),
      .o_tanswer_data_last    (tlast),
      .o_packet_size_in_bytes (psize),
      .o_grant_id             (grant_id),
      .o_busy                 (busy),
      .o_timeout              (timeout)
   );

   wire [29:0] obs = {busy, tanswer_ready, tdata, tlast, psize, grant_id, mgr_ready, timeout};

   function automatic logic [29:0] ev(logic b, logic tr, logic [7:0] td, logic tl,
                                      logic [11:0] ps, int gid, logic [3:0] mr, logic to);
      return {b, tr, td, tl, ps, 2'(gid), mr, to};
   endfunction

   function automatic logic [3:0] onehot_mr(int w, logic tm);
      logic [3:0] v;
      v = 4'b0;
      v[w] = tm;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_src(int k, logic r, logic [7:0] d, logic l, logic [11:0] s);
      req_ready[k]        = r;
      req_data[k*DW +: DW] = d;
      req_last[k]         = l;
      req_size[k*SW +: SW] = s;
   endtask

   task automatic do_reset();
      req_ready = '0; req_data = '0; req_last = '0; req_size = '0; tmgr_ready = 1'b0;
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      m_ptr = 0;
      m_gid = 0;
   endtask

   // Every listed source requests at once and keeps requesting until served;
   // the expected timeline is IDLE, GRANT, len STREAM beats, RELEASE per packet.
   task automatic stream_schedule(string name, logic [3:0] active, int minlen, int maxlen);
      int          len [4];
      logic [7:0]  dat [4][16];
      logic [11:0] sz  [4];
      logic [3:0]  pend;
      logic [29:0] e;
      logic        tm;
      int          w;
      pend = active;
      for (int k = 0; k < 4; k++) begin
         len[k] = $urandom_range(maxlen, minlen);
         sz[k]  = 12'($urandom);
         for (int b = 0; b < 16; b++) dat[k][b] = 8'($urandom);
      end
      while (pend != 4'b0) begin
         for (int k = 0; k < 4; k++)
            drive_src(k, pend[k], pend[k] ? dat[k][0] : 8'h0, pend[k] && len[k] == 1, pend[k] ? sz[k] : 12'h0);
         tmgr_ready = 1'($urandom);
         #1;
         e = ev(0, 0, 0, 0, 0, m_gid, 0, 0);
         total++;
         if (obs !== e) begin bad++; $display("FAIL %s_idle: got=%h expected=%h", name, obs, e); end
         w = -1;
         for (int i = 0; i < 4; i++)
            if (w < 0 && pend[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
         cyc();
         tmgr_ready = 1'($urandom);
         #1;
         e = ev(1, 0, 0, 0, 0, w, 0, 0);
         total++;
         if (obs !== e) begin bad++; $display("FAIL %s_grant: got=%h expected=%h", name, obs, e); end
         for (int b = 0; b < len[w]; b++) begin
            cyc();
            tm = 1'($urandom);
            tmgr_ready = tm;
            drive_src(w, 1'b1, dat[w][b], b == len[w] - 1, 12'($urandom));
            #1;
            e = ev(1, 1, dat[w][b], b == len[w] - 1, sz[w], w, onehot_mr(w, tm), 0);
            total++;
            if (obs !== e) begin bad++; $display("FAIL %s_beat%0d: got=%h expected=%h", name, b, obs, e); end
         end
         pend[w] = 1'b0;
         m_gid = w;
         m_ptr = (w + 1) % 4;
         cyc();
         drive_src(w, 1'b0, 8'h0, 1'b0, 12'h0);
         tmgr_ready = 1'($urandom);
         #1;
         e = ev(0, 0, 0, 0, 0, m_gid, 0, 0);
         total++;
         if (obs !== e) begin bad++; $display("FAIL %s_release: got=%h expected=%h", name, obs, e); end
         cyc();
      end
      #1;
      e = ev(0, 0, 0, 0, 0, m_gid, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL %s_final_idle: got=%h expected=%h", name, obs, e); end
   endtask

   task automatic test_reset();
      req_ready = 4'hF; req_data = 32'($urandom); req_last = 4'h0;
      req_size = 48'($urandom); tmgr_ready = 1'b1;
      rst = 1'b1;
      repeat (2) cyc();
      total++;
      if (obs !== 30'h0) begin bad++; $display("FAIL reset_outputs: got=%h expected=0", obs); end
      do_reset();
   endtask

   task automatic test_single_src();
      logic [29:0] e;
      do_reset();
      drive_src(2, 1'b1, 8'hA5, 1'b0, 12'd2);
      tmgr_ready = 1'b1;
      #1;
      e = ev(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t1_idle: got=%h expected=%h", obs, e); end
      cyc(); #1;
      e = ev(1, 0, 0, 0, 0, 2, 0, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t1_grant: got=%h expected=%h", obs, e); end
      cyc(); #1;
      e = ev(1, 1, 8'hA5, 0, 12'd2, 2, 4'b0100, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t1_byte0: got=%h expected=%h", obs, e); end
      cyc();
      drive_src(2, 1'b1, 8'h5A, 1'b1, 12'd2);
      #1;
      e = ev(1, 1, 8'h5A, 1, 12'd2, 2, 4'b0100, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t1_byte1: got=%h expected=%h", obs, e); end
      cyc();
      drive_src(2, 1'b0, 8'h0, 1'b0, 12'h0);
      #1;
      e = ev(0, 0, 0, 0, 0, 2, 0, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t1_release: got=%h expected=%h", obs, e); end
      m_gid = 2;
      m_ptr = 3;
      cyc();
      stream_schedule("t1_next", 4'b1101, 1, 3);
   endtask

   task automatic test_all_sources();
      do_reset();
      stream_schedule("t2_rr", 4'hF, 1, 1);
   endtask

   task automatic test_no_preempt();
      logic [7:0]  d [3];
      logic [11:0] s;
      logic [29:0] e;
      logic        tm;
      do_reset();
      s = 12'($urandom);
      for (int b = 0; b < 3; b++) d[b] = 8'($urandom);
      drive_src(1, 1'b1, d[0], 1'b0, s);
      #1;
      cyc(); #1;
      e = ev(1, 0, 0, 0, 0, 1, 0, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t3_grant: got=%h expected=%h", obs, e); end
      for (int b = 0; b < 3; b++) begin
         cyc();
         tm = 1'($urandom);
         tmgr_ready = tm;
         drive_src(1, 1'b1, d[b], b == 2, s);
         if (b == 1) begin
            drive_src(0, 1'b1, 8'($urandom), 1'b0, 12'($urandom));
            drive_src(3, 1'b1, 8'($urandom), 1'b0, 12'($urandom));
         end
         #1;
         e = ev(1, 1, d[b], b == 2, s, 1, onehot_mr(1, tm), 0);
         total++; if (obs !== e) begin bad++; $display("FAIL t3_src1_beat%0d: got=%h expected=%h", b, obs, e); end
      end
      cyc();
      drive_src(1, 1'b0, 8'h0, 1'b0, 12'h0);
      #1;
      e = ev(0, 0, 0, 0, 0, 1, 0, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t3_release: got=%h expected=%h", obs, e); end
      m_gid = 1;
      m_ptr = 2;
      cyc();
      stream_schedule("t3_after", 4'b1001, 1, 3);
   endtask

   task automatic test_timeout();
      logic [11:0] s;
      logic [7:0]  d;
      logic [29:0] e;
      logic        tm;
      do_reset();
      s = 12'($urandom);
      drive_src(0, 1'b1, 8'($urandom), 1'b0, s);
      drive_src(1, 1'b1, 8'($urandom), 1'b0, 12'($urandom));
      #1;
      cyc(); #1;
      e = ev(1, 0, 0, 0, 0, 0, 0, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t4_grant: got=%h expected=%h", obs, e); end
      for (int c = 0; c < TO; c++) begin
         cyc();
         d = 8'($urandom);
         tm = 1'($urandom);
         tmgr_ready = tm;
         drive_src(0, 1'b1, d, 1'b0, s);
         #1;
         e = ev(1, 1, d, 0, s, 0, onehot_mr(0, tm), 0);
         total++; if (obs !== e) begin bad++; $display("FAIL t4_stream%0d: got=%h expected=%h", c, obs, e); end
      end
      cyc();
      drive_src(0, 1'b0, 8'h0, 1'b0, 12'h0);
      #1;
      e = ev(0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (obs !== e) begin bad++; $display("FAIL t4_timeout_pulse: got=%h expected=%h", obs, e); end
      m_gid = 0;
      m_ptr = 1;
      cyc();
      stream_schedule("t4_next", 4'b0010, 1, 3);
      stream_schedule("t4_last_at_limit", 4'b0100, TO, TO);
   endtask

   task automatic test_abort();
      logic [7:0]  d [4];
      logic [11:0] s;
      logic [29:0] e;
      logic        tm;
      do_reset();
      s = 12'($urandom);
      for (int b = 0; b < 4; b++) d[b] = 8'($urandom);
      drive_src(1, 1'b1, d[0], 1'b0, s);
      #1;
      cyc();
      for (int b = 0; b < 4; b++) begin
         cyc();
         tm = 1'($urandom);
         tmgr_ready = tm;
         drive_src(1, b < 3, d[b], 1'b0, s);
         #1;
         e = ev(1, b < 3, d[b], 0, s, 1, onehot_mr(1, tm), 0);
         total++; if (obs !== e) begin bad++; $display("FAIL t5_cycle%0d: got=%h expected=%h", b, obs, e); end
      end
      cyc(); #1;
      e = ev(0, 0, 0, 0, 0, 1, 0, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t5_release_no_timeout: got=%h expected=%h", obs, e); end
      m_gid = 1;
      m_ptr = 2;
      cyc();
      stream_schedule("t5_after", 4'b1101, 1, 3);
   endtask

   task automatic test_reset_mid_packet();
      logic [29:0] e;
      do_reset();
      stream_schedule("t6_pre", 4'b0010, 1, 2);
      drive_src(2, 1'b1, 8'($urandom), 1'b0, 12'hABC);
      tmgr_ready = 1'b1;
      repeat (3) cyc();
      #1;
      e = ev(1, 1, req_data[2*DW +: DW], 0, 12'hABC, 2, 4'b0100, 0);
      total++; if (obs !== e) begin bad++; $display("FAIL t6_streaming: got=%h expected=%h", obs, e); end
      rst = 1'b1;
      cyc(); #1;
      total++; if (obs !== 30'h0) begin bad++; $display("FAIL t6_reset_mid: got=%h expected=0", obs); end
      rst = 1'b0;
      drive_src(2, 1'b0, 8'h0, 1'b0, 12'h0);
      m_ptr = 0;
      m_gid = 0;
      stream_schedule("t6_after", 4'b1001, 1, 3);
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++)
         stream_schedule("rand", 4'($urandom_range(15, 1)), 1, 6);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req_ready = '0; req_data = '0; req_last = '0; req_size = '0; tmgr_ready = 1'b0;
      test_reset();
      test_single_src();
      test_all_sources();
      test_no_preempt();
      test_timeout();
      test_abort();
      test_reset_mid_packet();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
